// File: rtl/mips_pkg.sv
// Shared encodings for the mips_cpu memory-port arbiter.
package mips_pkg;

  // Arbiter FSM encoding
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUSY = 2'd1;
  localparam logic [1:0] ARB_DONE = 2'd2;

  // Grant encoding
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  // Latency counter width; MEM_LAT must fit (1..15)
  localparam int unsigned LAT_CNT_W = 4;

  // D wins a tie unless it had the previous grant, so IF is never starved
  function automatic logic pick_grant(input logic if_elig, input logic d_req,
                                      input logic last_grant);
    return (d_req && !(if_elig && last_grant == GNT_D)) ? GNT_D : GNT_IF;
  endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter that times the fixed memory read latency.
module mem_lat_timer
  import mips_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

  // Reload on issue, count down while the access is in flight
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LAT_CNT_W'(MEM_LAT);
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - LAT_CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_cancel,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0]    state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic          acc_we_q, acc_we_d;
  logic          cancel_q, cancel_d;
  logic          if_done_q, if_done_d;
  logic          d_ready_q, d_ready_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic timer_load, timer_dec, timer_zero;
  logic if_elig, issue_gnt;

  mem_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .dec   (timer_dec),
    .zero  (timer_zero)
  );

  assign if_elig   = if_req & ~if_cancel;
  assign issue_gnt = pick_grant(if_elig, d_req, last_grant_q);

  // Arbitration, issue, latency wait and completion
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    acc_we_d     = acc_we_q;
    cancel_d     = cancel_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_done_d    = 1'b0;
    d_ready_d    = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    timer_load   = 1'b0;
    timer_dec    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (if_elig || d_req) begin
          state_d      = ARB_BUSY;
          grant_d      = issue_gnt;
          last_grant_d = issue_gnt;
          acc_we_d     = (issue_gnt == GNT_D) ? d_we : 1'b0;
          cancel_d     = 1'b0;
          mem_en_d     = 1'b1;
          mem_we_d     = (issue_gnt == GNT_D) ? d_we : 1'b0;
          mem_addr_d   = (issue_gnt == GNT_D) ? d_addr : if_addr;
          mem_wdata_d  = (issue_gnt == GNT_D) ? d_wdata : '0;
          timer_load   = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (grant_q == GNT_IF && if_cancel) cancel_d = 1'b1;
        if (timer_zero) begin
          state_d = ARB_DONE;
          if (grant_q == GNT_D) begin
            d_rdata_d = acc_we_q ? '0 : mem_rdata;
            d_ready_d = 1'b1;
          end else if (!cancel_q && !if_cancel) begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end
        end else begin
          timer_dec = 1'b1;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      grant_q      <= GNT_IF;
      last_grant_q <= GNT_IF;
      acc_we_q     <= 1'b0;
      cancel_q     <= 1'b0;
      if_done_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      acc_we_q     <= acc_we_d;
      cancel_q     <= cancel_d;
      if_done_q    <= if_done_d;
      d_ready_q    <= d_ready_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // A granted requester must keep req high until its ready (cancelled fetches excepted)
  always_ff @(posedge clk) begin
    if (!reset && state_q != ARB_IDLE) begin
      if (grant_q == GNT_D) assert (d_req);
      else                  assert (if_req || if_cancel || cancel_q);
    end
  end

  // A cancel landing in the DONE cycle still suppresses the fetch pulse
  assign if_ready  = if_done_q & ~if_cancel;
  assign d_ready   = d_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_if  = if_req & ~if_ready & ~if_cancel;
  assign stall_mem = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: three arbiter builds (MEM_LAT 2, 1, 5) against a timeline model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  if_req, d_req;
  logic        if_cancel, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;

  logic [2:0]  if_ready_w, d_ready_w, stall_if_w, stall_mem_w, mem_en_w, mem_we_w;
  logic [31:0] if_rdata_w [3];
  logic [31:0] d_rdata_w  [3];
  logic [31:0] mem_addr_w [3];
  logic [31:0] mem_wdata_w[3];
  logic [31:0] mem_rdata_w[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(
      .AW      (32),
      .DW      (32),
      .MEM_LAT (g == 0 ? 2 : (g == 1 ? 1 : 5))
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req[g]),
      .if_addr   (if_addr),
      .if_cancel (if_cancel),
      .if_rdata  (if_rdata_w[g]),
      .if_ready  (if_ready_w[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata_w[g]),
      .d_ready   (d_ready_w[g]),
      .stall_if  (stall_if_w[g]),
      .stall_mem (stall_mem_w[g]),
      .mem_en    (mem_en_w[g]),
      .mem_we    (mem_we_w[g]),
      .mem_addr  (mem_addr_w[g]),
      .mem_wdata (mem_wdata_w[g]),
      .mem_rdata (mem_rdata_w[g])
    );
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] iss[$];

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  // Memory contents: data is a fixed function of the address
  function automatic logic [31:0] memval(input logic [31:0] a);
    return a ^ 32'h2042_0005;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory: returns data exactly MEM_LAT cycles after the strobe, junk otherwise
  bit          pend_v [3];
  int          pend_c [3];
  bit [31:0]   pend_a [3];
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      mem_rdata_w[i] = (pend_v[i] && cyc == pend_c[i]) ? memval(pend_a[i])
                                                      : (32'hBAD0_0000 ^ 32'(cyc));
  end

  // Model: each access is a timeline offset k from the cycle its request was sampled
  bit        m_busy [3];
  bit        m_gnt  [3];
  bit        m_last [3];
  bit        m_we   [3];
  bit        m_canc [3];
  int        m_t0   [3];
  bit [31:0] m_addr [3];
  bit [31:0] m_wdata[3];
  bit [31:0] m_ifr  [3];
  bit [31:0] m_dr   [3];
  int  k, lat;
  bit  e_men, e_mwe, e_dr, e_ifr, elig;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      lat   = lat_of(i);
      k     = cyc - m_t0[i];
      e_men = m_busy[i] && k == 1;
      e_mwe = e_men && m_gnt[i] && m_we[i];
      e_dr  = m_busy[i] && m_gnt[i] && k == lat + 2;
      e_ifr = m_busy[i] && !m_gnt[i] && k == lat + 2 && !m_canc[i] && !if_cancel;
      check($sformatf("i%0d mem_en c%0d", i, cyc), 32'(mem_en_w[i]), 32'(e_men));
      check($sformatf("i%0d mem_we c%0d", i, cyc), 32'(mem_we_w[i]), 32'(e_mwe));
      check($sformatf("i%0d d_ready c%0d", i, cyc), 32'(d_ready_w[i]), 32'(e_dr));
      check($sformatf("i%0d if_ready c%0d", i, cyc), 32'(if_ready_w[i]), 32'(e_ifr));
      check($sformatf("i%0d stall_if c%0d", i, cyc), 32'(stall_if_w[i]),
            32'(if_req[i] && !e_ifr && !if_cancel));
      check($sformatf("i%0d stall_mem c%0d", i, cyc), 32'(stall_mem_w[i]),
            32'(d_req[i] && !e_dr));
      check($sformatf("i%0d if_rdata c%0d", i, cyc), if_rdata_w[i], m_ifr[i]);
      check($sformatf("i%0d d_rdata c%0d", i, cyc), d_rdata_w[i], m_dr[i]);
      check($sformatf("i%0d mem_addr c%0d", i, cyc), mem_addr_w[i], m_addr[i]);
      if (e_mwe)
        check($sformatf("i%0d mem_wdata c%0d", i, cyc), mem_wdata_w[i], m_wdata[i]);

      if (mem_en_w[i]) begin
        pend_v[i] = 1'b1;
        pend_c[i] = cyc + lat;
        pend_a[i] = mem_addr_w[i];
      end

      if (reset) begin
        m_busy[i] = 1'b0; m_last[i] = 1'b0; m_addr[i] = '0;
        m_ifr[i]  = '0;   m_dr[i]   = '0;
      end else if (m_busy[i]) begin
        if (!m_gnt[i] && k >= 1 && k <= lat + 1 && if_cancel) m_canc[i] = 1'b1;
        if (k == lat + 1) begin
          if (m_gnt[i])        m_dr[i]  = m_we[i] ? 32'h0 : memval(m_addr[i]);
          else if (!m_canc[i]) m_ifr[i] = memval(m_addr[i]);
        end
        if (k == lat + 2) m_busy[i] = 1'b0;
      end else begin
        elig = if_req[i] && !if_cancel;
        if (elig || d_req[i]) begin
          m_busy[i]  = 1'b1;
          m_t0[i]    = cyc;
          m_gnt[i]   = d_req[i] && !(elig && m_last[i]);
          m_last[i]  = m_gnt[i];
          m_we[i]    = m_gnt[i] ? d_we : 1'b0;
          m_addr[i]  = m_gnt[i] ? d_addr : if_addr;
          m_wdata[i] = d_wdata;
          m_canc[i]  = 1'b0;
        end
      end
    end
    cyc++;
  end

  task automatic wait_ready(input int i, input bit is_d, input string nm);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      if (mem_en_w[i]) iss.push_back(mem_addr_w[i]);
      got = is_d ? d_ready_w[i] : if_ready_w[i];
      n++;
    end
    check({nm, " ready seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ens[$];
    int nr, first_r, nw, ndr;
    reset = 1'b1; if_req = '0; d_req = '0; if_cancel = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) tick;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst i%0d mem_en", i), 32'(mem_en_w[i]), 32'd0);
      check($sformatf("rst i%0d ready", i), 32'({if_ready_w[i], d_ready_w[i]}), 32'd0);
      check($sformatf("rst i%0d mem_addr", i), mem_addr_w[i], 32'd0);
      check($sformatf("rst i%0d rdata", i), if_rdata_w[i] | d_rdata_w[i], 32'd0);
    end

    // 1: single fetch
    tick;
    if_addr = 32'h0040_0000; if_req[0] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check($sformatf("t1 mem_en j%0d", j), 32'(mem_en_w[0]), 32'(j == 1));
      check($sformatf("t1 stall_if j%0d", j), 32'(stall_if_w[0]), 32'(j < 4));
      check($sformatf("t1 if_ready j%0d", j), 32'(if_ready_w[0]), 32'(j == 4));
    end
    check("t1 if_rdata", if_rdata_w[0], 32'h2002_0005);
    tick;
    if_req[0] = 1'b0;

    // 2: simultaneous requests, then both held
    tick;
    if_addr = 32'h0040_0010; d_addr = 32'h1000_0020; d_we = 1'b0;
    if_req[0] = 1'b1; d_req[0] = 1'b1;
    iss.delete();
    wait_ready(0, 1'b1, "t2a d");
    tick;
    d_req[0] = 1'b0;
    wait_ready(0, 1'b0, "t2a if");
    check("t2a issues", 32'(iss.size()), 32'd2);
    if (iss.size() == 2) begin
      check("t2a first=D", iss[0], 32'h1000_0020);
      check("t2a second=IF", iss[1], 32'h0040_0010);
    end
    tick;
    d_req[0] = 1'b1;
    iss.delete();
    wait_ready(0, 1'b1, "t2b d1");
    wait_ready(0, 1'b0, "t2b if1");
    wait_ready(0, 1'b1, "t2b d2");
    wait_ready(0, 1'b0, "t2b if2");
    tick;
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    check("t2b issues", 32'(iss.size()), 32'd4);
    if (iss.size() == 4) begin
      check("t2b g0=D", iss[0], 32'h1000_0020);
      check("t2b g1=IF", iss[1], 32'h0040_0010);
      check("t2b g2=D", iss[2], 32'h1000_0020);
      check("t2b g3=IF", iss[3], 32'h0040_0010);
    end
    check("t2 if_rdata", if_rdata_w[0], 32'h2002_0015);
    check("t2 d_rdata", d_rdata_w[0], 32'h3042_0025);

    // 3: store
    tick;
    d_we = 1'b1; d_addr = 32'h1000_0010; d_wdata = 32'hDEAD_BEEF; d_req[0] = 1'b1;
    nw = 0; ndr = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (mem_en_w[0] && mem_we_w[0]) begin
        nw++;
        check("t3 mem_addr", mem_addr_w[0], 32'h1000_0010);
        check("t3 mem_wdata", mem_wdata_w[0], 32'hDEAD_BEEF);
      end
      if (d_ready_w[0]) ndr++;
      check($sformatf("t3 d_ready j%0d", j), 32'(d_ready_w[0]), 32'(j == 4));
    end
    check("t3 d_rdata", d_rdata_w[0], 32'h0);
    tick;
    d_req[0] = 1'b0; d_we = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d_ready_w[0]) ndr++;
    end
    check("t3 write strobes", 32'(nw), 32'd1);
    check("t3 d_ready pulses", 32'(ndr), 32'd1);

    // 4: fetch cancelled while in flight
    for (int j = 0; j < 7; j++) begin
      tick;
      case (j)
        0: begin if_addr = 32'h0040_0100; if_req[0] = 1'b1; end
        2: begin if_cancel = 1'b1; if_req[0] = 1'b0; end
        3: if_cancel = 1'b0;
        5: begin d_addr = 32'h1000_0040; d_we = 1'b0; d_req[0] = 1'b1; end
        default: ;
      endcase
      @(negedge clk);
      if (j < 6) check($sformatf("t4 if_ready j%0d", j), 32'(if_ready_w[0]), 32'd0);
      else begin
        check("t4 idle at j5", 32'(mem_en_w[0]), 32'd1);
        check("t4 d issue addr", mem_addr_w[0], 32'h1000_0040);
      end
    end
    wait_ready(0, 1'b1, "t4 d");
    tick;
    d_req[0] = 1'b0;
    check("t4 if_rdata kept", if_rdata_w[0], 32'h2002_0015);
    check("t4 d_rdata", d_rdata_w[0], 32'h3042_0045);

    // 5: reset in the middle of a load
    for (int j = 0; j < 10; j++) begin
      tick;
      case (j)
        0: begin d_addr = 32'h1000_0080; d_we = 1'b0; d_req[0] = 1'b1; end
        2: begin reset = 1'b1; d_req[0] = 1'b0; end
        3: reset = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      check($sformatf("t5 d_ready j%0d", j), 32'(d_ready_w[0]), 32'd0);
      if (j == 1) check("t5 mem_en", 32'(mem_en_w[0]), 32'd1);
      if (j == 3) begin
        check("t5 mem_addr", mem_addr_w[0], 32'd0);
        check("t5 mem_en/we", 32'({mem_en_w[0], mem_we_w[0]}), 32'd0);
        check("t5 mem_wdata", mem_wdata_w[0], 32'd0);
        check("t5 if_rdata", if_rdata_w[0], 32'd0);
        check("t5 d_rdata", d_rdata_w[0], 32'd0);
      end
    end

    // 6: latency and back-to-back spacing per build
    for (int i = 0; i < 3; i++) begin
      tick;
      d_addr = 32'h1000_0100 + 32'(i * 4); d_we = 1'b0; d_req[i] = 1'b1;
      ens.delete(); nr = 0; first_r = -1;
      for (int j = 0; j < 80 && nr < 3; j++) begin
        @(negedge clk);
        if (mem_en_w[i]) ens.push_back(j);
        if (d_ready_w[i]) begin
          nr++;
          if (nr == 1) first_r = j;
        end
      end
      tick;
      d_req[i] = 1'b0;
      check($sformatf("t6 i%0d readies", i), 32'(nr), 32'd3);
      check($sformatf("t6 i%0d first ready", i), 32'(first_r),
            (i == 0) ? 32'd4 : (i == 1) ? 32'd3 : 32'd7);
      check($sformatf("t6 i%0d issues", i), 32'(ens.size()), 32'd3);
      if (ens.size() == 3) begin
        check($sformatf("t6 i%0d first mem_en", i), 32'(ens[0]), 32'd1);
        check($sformatf("t6 i%0d spacing a", i), 32'(ens[1] - ens[0]),
              (i == 0) ? 32'd5 : (i == 1) ? 32'd4 : 32'd8);
        check($sformatf("t6 i%0d spacing b", i), 32'(ens[2] - ens[1]),
              (i == 0) ? 32'd5 : (i == 1) ? 32'd4 : 32'd8);
      end
    end

    repeat (3) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
